// File: rtl/famicom_pad.sv
// 4021-style controller responder on the $4016 D0 line: OUT_0 strobes a parallel
// load of the buttons, the rising edge of P4016_CUP shifts the next bit out.
module famicom_pad #(
    parameter int SYNC_STAGES  = 2,
    parameter int TURBO_PERIOD = 2
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       OUT_0,
    input  logic       P4016_CUP,
    input  logic [7:0] BTN,
    input  logic [1:0] TURBO_EN,
    output logic       P4016_D0,
    output logic [3:0] BIT_IDX
);

    typedef enum logic {ST_LOAD, ST_SHIFT} state_t;

    localparam logic [3:0] TC_LAST = 4'(TURBO_PERIOD - 1);

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_strb_sync, r_cup_sync;
    logic                   r_strb_d, r_cup_d;
    logic [7:0]             r_sr, w_sr_nxt;
    logic [3:0]             r_bit_idx, w_idx_nxt;
    logic [3:0]             r_tc;
    logic                   r_ph;
    logic                   r_d0;

    logic       w_strb, w_cup, w_strb_fall, w_cup_rise;
    logic [7:0] w_eff;

    assign w_strb      = r_strb_sync[SYNC_STAGES-1];
    assign w_cup       = r_cup_sync[SYNC_STAGES-1];
    assign w_strb_fall = ~w_strb & r_strb_d;
    assign w_cup_rise  = w_cup & ~r_cup_d;

    // Turbo gates A/B with the phase bit; directions pass through unfiltered.
    assign w_eff = {BTN[7:2],
                    BTN[1] & (~TURBO_EN[1] | r_ph),
                    BTN[0] & (~TURBO_EN[0] | r_ph)};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_strb_sync <= '0;
            r_cup_sync  <= '1;
            r_strb_d    <= 1'b0;
            r_cup_d     <= 1'b1;
        end else begin
            r_strb_sync <= {r_strb_sync[SYNC_STAGES-2:0], OUT_0};
            r_cup_sync  <= {r_cup_sync[SYNC_STAGES-2:0], P4016_CUP};
            r_strb_d    <= w_strb;
            r_cup_d     <= w_cup;
        end
    end

    // A high strobe loads immediately, so a simultaneous CUP rise never shifts.
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_idx_nxt   = r_bit_idx;
        case (r_state)
            ST_LOAD: begin
                if (w_strb_fall) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_sr_nxt  = w_eff;
                    w_idx_nxt = 4'd0;
                end
            end
            default: begin
                if (w_strb) begin
                    w_state_nxt = ST_LOAD;
                    w_sr_nxt    = w_eff;
                    w_idx_nxt   = 4'd0;
                end else if (w_cup_rise) begin
                    w_sr_nxt  = {1'b1, r_sr[7:1]};
                    w_idx_nxt = (r_bit_idx >= 4'd8) ? 4'd8 : r_bit_idx + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= ST_SHIFT;
            r_sr      <= 8'h00;
            r_bit_idx <= 4'd0;
            r_d0      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_sr_nxt;
            r_bit_idx <= w_idx_nxt;
            r_d0      <= ~w_sr_nxt[0];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_tc <= 4'd0;
            r_ph <= 1'b1;
        end else if (w_strb_fall) begin
            if (r_tc >= TC_LAST) begin
                r_tc <= 4'd0;
                r_ph <= ~r_ph;
            end else begin
                r_tc <= r_tc + 4'd1;
            end
        end
    end

    assign P4016_D0 = r_d0;
    assign BIT_IDX  = r_bit_idx;

endmodule

// File: tb/tb_famicom_pad.sv
// Directed bench for famicom_pad: frame reads, saturation, restrobe, turbo, load priority, reset abort.
module tb_famicom_pad;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       OUT_0;
    logic       P4016_CUP;
    logic [7:0] BTN;
    logic [1:0] TURBO_EN;
    logic       P4016_D0;
    logic [3:0] BIT_IDX;

    int n_tests = 0;
    int n_fail  = 0;

    famicom_pad #(.SYNC_STAGES(2), .TURBO_PERIOD(2)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .OUT_0    (OUT_0),
        .P4016_CUP(P4016_CUP),
        .BTN      (BTN),
        .TURBO_EN (TURBO_EN),
        .P4016_D0 (P4016_D0),
        .BIT_IDX  (BIT_IDX)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic strobe();
        OUT_0 = 1'b1;
        wait_cyc(6);
        OUT_0 = 1'b0;
        wait_cyc(6);
    endtask

    task automatic cup_pulse();
        P4016_CUP = 1'b0;
        wait_cyc(6);
        P4016_CUP = 1'b1;
        wait_cyc(6);
    endtask

    logic [7:0] exp_seq;
    logic [7:0] turbo_exp;

    initial begin
        nRST      = 1'b0;
        OUT_0     = 1'b0;
        P4016_CUP = 1'b1;
        BTN       = 8'h00;
        TURBO_EN  = 2'b00;
        wait_cyc(3);
        chk("reset_d0", {7'd0, P4016_D0}, 8'd1);
        chk("reset_idx", {4'd0, BIT_IDX}, 8'd0);
        nRST = 1'b1;
        wait_cyc(3);

        // Turbo on A, period 2: phase starts high, flips every second frame
        TURBO_EN  = 2'b01;
        BTN       = 8'h01;
        turbo_exp = 8'b11001100;   // bit k = expected first read of frame k
        for (int f = 0; f < 8; f++) begin
            strobe();
            chk($sformatf("turbo_f%0d", f), {7'd0, P4016_D0}, {7'd0, turbo_exp[f]});
        end
        TURBO_EN = 2'b00;

        // A + Start frame; buttons change during shift and must be ignored
        BTN = 8'h09;
        strobe();
        BTN     = 8'hF6;
        exp_seq = 8'b11110110;     // bit k = expected read k (active-low)
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("frame_d0_%0d", k), {7'd0, P4016_D0}, {7'd0, exp_seq[k]});
            cup_pulse();
            chk($sformatf("frame_idx_%0d", k), {4'd0, BIT_IDX}, 8'(k + 1));
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sat_d0_%0d", k), {7'd0, P4016_D0}, 8'd0);
            cup_pulse();
            chk($sformatf("sat_idx_%0d", k), {4'd0, BIT_IDX}, 8'd8);
        end

        // Restrobe mid-frame with only Right pressed
        BTN = 8'h80;
        strobe();
        for (int k = 0; k < 3; k++) cup_pulse();
        OUT_0 = 1'b1;
        wait_cyc(6);
        chk("restrobe_idx", {4'd0, BIT_IDX}, 8'd0);
        chk("restrobe_d0", {7'd0, P4016_D0}, 8'd1);
        OUT_0 = 1'b0;
        wait_cyc(6);
        for (int k = 0; k < 7; k++) cup_pulse();
        chk("right_d0", {7'd0, P4016_D0}, 8'd0);
        chk("right_idx", {4'd0, BIT_IDX}, 8'd7);

        // CUP rise coincident with strobe rise: load wins, no shift
        BTN       = 8'h02;
        P4016_CUP = 1'b0;
        wait_cyc(6);
        OUT_0     = 1'b1;
        P4016_CUP = 1'b1;
        wait_cyc(6);
        OUT_0 = 1'b0;
        wait_cyc(6);
        chk("coinc_idx", {4'd0, BIT_IDX}, 8'd0);
        chk("coinc_bit0", {7'd0, P4016_D0}, 8'd1);
        cup_pulse();
        chk("coinc_bit1", {7'd0, P4016_D0}, 8'd0);

        // Reset mid-frame after 4 shifts, then a clean frame
        BTN = 8'h0F;
        strobe();
        for (int k = 0; k < 4; k++) cup_pulse();
        chk("pre_rst_idx", {4'd0, BIT_IDX}, 8'd4);
        #2 nRST = 1'b0;
        #1;
        chk("rst_abort_d0", {7'd0, P4016_D0}, 8'd1);
        chk("rst_abort_idx", {4'd0, BIT_IDX}, 8'd0);
        wait_cyc(2);
        nRST = 1'b1;
        wait_cyc(3);
        BTN = 8'h09;
        strobe();
        BTN = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("post_rst_d0_%0d", k), {7'd0, P4016_D0}, {7'd0, exp_seq[k]});
            cup_pulse();
        end
        chk("post_rst_idx", {4'd0, BIT_IDX}, 8'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/famicom_pad.md
FAMICOM_PAD -- requirements
Module: famicom_pad

Console-side controller responder: a 4021-style parallel-in/serial-out pad driving the $4016 D0 line, with OUT_0 as strobe and P4016_CUP as read clock.

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for OUT_0 and P4016_CUP; legal range 2..4.
REQ-002 Parameter TURBO_PERIOD, default 2: number of strobe falling edges per turbo phase toggle; legal range 1..15.
REQ-003 CLK  in  1  system clock; the minimum OUT_0/P4016_CUP pulse width is at least SYNC_STAGES+2 CLK periods.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 OUT_0  in  1  strobe from the console; high means continuous parallel load.
REQ-006 P4016_CUP  in  1  active-low read clock from the console; its rising edge ends a read and shifts.
REQ-007 BTN  in  8  buttons, active-high; bit0..7 = A, B, Select, Start, Up, Down, Left, Right.
REQ-008 TURBO_EN  in  2  turbo enables; bit0 = A, bit1 = B.
REQ-009 P4016_D0  out  1  serial pad data, active-low (0 = pressed), before the console's inverting buffer.
REQ-010 BIT_IDX  out  4  number of shifts since the last load, saturating at 8.

Function
REQ-011 OUT_0 and P4016_CUP SHALL each pass through a SYNC_STAGES flop chain; chain reset values are 0 for OUT_0 and 1 for CUP.
REQ-012 Edges SHALL be detected on synchronized signals only: strobe rise, strobe fall, CUP rise.
REQ-013 FSM states SHALL be LOAD and SHIFT; the reset state is SHIFT.
REQ-014 LOAD: every CLK the shift register SR[7:0] SHALL load EFF[7:0]; BIT_IDX SHALL be 0.
REQ-015 LOAD -> SHIFT on synchronized strobe fall; SR SHALL hold the value loaded in the last LOAD cycle.
REQ-016 SHIFT -> LOAD on synchronized strobe high, effective the same cycle the high level is seen, regardless of BIT_IDX.
REQ-017 SHIFT, on CUP rise: SR <= {1'b1, SR[7:1]}; BIT_IDX <= min(BIT_IDX+1, 8).
REQ-018 CUP rise while in LOAD, or in the same cycle as a strobe rise, SHALL NOT shift; the load wins.
REQ-019 P4016_D0 SHALL equal ~SR[0], registered, at all times, including during LOAD.
REQ-020 Latency from a CUP rising edge at the pin to the new P4016_D0 SHALL be at most SYNC_STAGES+2 CLK cycles.
REQ-021 After 8 shifts, P4016_D0 SHALL read 0 indefinitely until the next load, so the console sees 1.
REQ-022 EFF[i] = BTN[i] for i = 2..7, with no filtering; Up+Down and Left+Right pass through unchanged.
REQ-023 Turbo counter TC (4 bit) SHALL increment on each strobe fall and wrap to 0 after TURBO_PERIOD-1; phase bit PH toggles on each wrap.
REQ-024 EFF[0] = BTN[0] & (~TURBO_EN[0] | PH); EFF[1] = BTN[1] & (~TURBO_EN[1] | PH).
REQ-025 BTN and TURBO_EN SHALL be sampled only in LOAD; changes during SHIFT SHALL NOT affect SR.

Reset
REQ-026 nRST low SHALL asynchronously set SR = 8'h00, P4016_D0 = 1, BIT_IDX = 0, TC = 0, PH = 1, state SHIFT, and the sync chains to their REQ-011 values.
REQ-027 After nRST deasserts, the first state change SHALL occur only after a synchronized strobe edge.
REQ-028 nRST asserted mid-shift SHALL abort the sequence; no partial SR value survives.

Verification
REQ-029 BTN=8'h09 (A, Start), strobe pulse, then 8 CUP pulses: P4016_D0 sequence 0,1,1,0,1,1,1,1; BIT_IDX 1..8.
REQ-030 Continuing with 3 further CUP pulses: P4016_D0 = 0 every read; BIT_IDX stays at 8.
REQ-031 Strobe raised after 3 shifts with BTN=8'h80: BIT_IDX = 0, P4016_D0 = 1; after 7 shifts, P4016_D0 = 0 (Right).
REQ-032 TURBO_PERIOD=2, TURBO_EN=2'b01, BTN=8'h01 held over 8 frames: first-bit sequence 0,0,1,1,0,0,1,1.
REQ-033 CUP rise and strobe rise in the same synchronized cycle with BTN=8'h02: no shift; first bit after the load is 1 and second bit is 0.
REQ-034 nRST pulsed mid-frame after 4 shifts: P4016_D0 = 1 and BIT_IDX = 0 immediately; the next full frame reads correctly.
